data_sram_responder: RTL

//  Responder end of the core's data SRAM interface (en/we/addr/wdata -> rdata).
//  - Decodes each access to word-addressed RAM or to a small MMIO register block.
//  - MMIO block: free-running timer with compare interrupt, LED register, UART-style TX byte FIFO.
//  - Sits beside the core in the SoC top; drives the core's data_sram_rdata.

---
 rtl/data_sram_responder_pkg.sv | 25 ++
 rtl/data_sram_responder_if.sv | 21 ++
 rtl/data_sram_responder_tx_fifo.sv | 52 +++++
 rtl/data_sram_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder: MMIO register offsets,
// STATUS bit positions, LED width and the access-region type.
package data_sram_responder_pkg;

  localparam logic [7:0] MMIO_TIMER_OFF  = 8'h00;
  localparam logic [7:0] MMIO_CMP_OFF    = 8'h04;
  localparam logic [7:0] MMIO_STATUS_OFF = 8'h08;
  localparam logic [7:0] MMIO_TXDATA_OFF = 8'h0C;
  localparam logic [7:0] MMIO_LED_OFF    = 8'h10;
  localparam logic [7:0] MMIO_RDCNT_OFF  = 8'h14;
  localparam logic [7:0] MMIO_WRCNT_OFF  = 8'h18;

  localparam int STATUS_IRQ_BIT   = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;

  localparam int LED_W = 16;

  typedef enum logic {
    REGION_RAM  = 1'b0,
    REGION_MMIO = 1'b1
  } region_e;

endpackage

// File: rtl/data_sram_responder_if.sv
// Core-side data SRAM bus. Request-only protocol: the core asserts
// data_sram_en for one cycle per access (no ready/backpressure); for a read
// (we==0) data_sram_rdata is valid from the following cycle and is held until
// the next read completes.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder_tx_fifo.sv
// Small synchronous byte FIFO for the TX path. The caller only pushes when
// there is room (or when a pop frees the head slot in the same cycle) and only
// pops when non-empty; the head entry is presented combinationally.
module resp_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
endmodule

// File: rtl/data_sram_responder.sv
// Responder for the core's data SRAM port: word RAM plus an MMIO block with a
// free-running timer/compare interrupt, an LED register and a TX byte FIFO.
// Optional macro DATA_RESP_PERF_EN adds read/write access counters at
// offsets 0x14/0x18; without it those offsets read 0 and ignore writes.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          TX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_sram_responder_if.slave bus,
  output logic                 timer_irq_o,
  output logic [LED_W-1:0]     led_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i
);
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]       r_ram [2**RAM_AW];
  logic [31:0]       r_rdata;
  logic [31:0]       r_timer;
  logic [31:0]       r_cmp;
  logic              r_irq;
  logic              r_ovf;
  logic [LED_W-1:0]  r_led;

  region_e           w_region;
  logic [7:0]        w_off;
  logic [RAM_AW-1:0] w_idx;
  logic              w_rd;
  logic              w_wr;
  logic              w_mmio_wr;
  logic              w_ram_wr;
  logic              w_wr_timer, w_wr_cmp, w_wr_status, w_wr_tx, w_wr_led;
  logic [31:0]       w_timer_nxt;
  logic              w_irq_set;
  logic              w_pop, w_push, w_ovf_set;
  logic              w_tx_full, w_tx_empty;
  logic [TX_CW-1:0]  w_tx_count;
  logic [31:0]       w_status;
  logic [31:0]       w_mmio_rd;
  logic              w_unused;

  assign w_region = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]) ? REGION_MMIO : REGION_RAM;
  assign w_off    = bus.data_sram_addr[7:0];
  assign w_idx    = bus.data_sram_addr[RAM_AW+1:2];
  assign w_rd     = bus.data_sram_en & ~|bus.data_sram_we;
  assign w_wr     = bus.data_sram_en &  |bus.data_sram_we;
  assign w_ram_wr = w_wr & (w_region == REGION_RAM);
  // MMIO registers only react to full-word writes.
  assign w_mmio_wr   = bus.data_sram_en & (w_region == REGION_MMIO) & (bus.data_sram_we == 4'hF);
  assign w_wr_timer  = w_mmio_wr & (w_off == MMIO_TIMER_OFF);
  assign w_wr_cmp    = w_mmio_wr & (w_off == MMIO_CMP_OFF);
  assign w_wr_status = w_mmio_wr & (w_off == MMIO_STATUS_OFF);
  assign w_wr_tx     = w_mmio_wr & (w_off == MMIO_TXDATA_OFF);
  assign w_wr_led    = w_mmio_wr & (w_off == MMIO_LED_OFF);

  // A timer load replaces that cycle's increment; irq compares the value about to be stored.
  assign w_timer_nxt = w_wr_timer ? bus.data_sram_wdata : r_timer + 32'd1;
  assign w_irq_set   = (w_timer_nxt == r_cmp);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pop     = ~w_tx_empty & tx_ready_i;
  assign w_push    = w_wr_tx & (~w_tx_full | w_pop);
  assign w_ovf_set = w_wr_tx & ~w_push;

  resp_tx_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.data_sram_wdata[7:0]),
    .o_data  (tx_data_o),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  // RAM with per-byte write enables; not reset. The registered read below
  // samples the old word, so a same-word read/write is read-first.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_we[b]) r_ram[w_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
      end
    end
  end

`ifdef DATA_RESP_PERF_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  // Access counters; a full-word write to a counter clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_mmio_wr && w_off == MMIO_RDCNT_OFF) r_rd_cnt <= '0;
      else if (w_rd)                            r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_mmio_wr && w_off == MMIO_WRCNT_OFF) r_wr_cnt <= '0;
      else if (w_wr)                            r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end
`endif

  // MMIO read mux; unmapped and write-only offsets return zero.
  always_comb begin
    w_status = '0;
    w_status[STATUS_IRQ_BIT]   = r_irq;
    w_status[STATUS_FULL_BIT]  = w_tx_full;
    w_status[STATUS_EMPTY_BIT] = w_tx_empty;
    w_status[STATUS_OVF_BIT]   = r_ovf;
    w_mmio_rd = '0;
    case (w_off)
      MMIO_TIMER_OFF:  w_mmio_rd = r_timer;
      MMIO_CMP_OFF:    w_mmio_rd = r_cmp;
      MMIO_STATUS_OFF: w_mmio_rd = w_status;
      MMIO_LED_OFF:    w_mmio_rd = {{(32-LED_W){1'b0}}, r_led};
`ifdef DATA_RESP_PERF_EN
      MMIO_RDCNT_OFF:  w_mmio_rd = r_rd_cnt;
      MMIO_WRCNT_OFF:  w_mmio_rd = r_wr_cnt;
`endif
      default:         w_mmio_rd = '0;
    endcase
  end

  // Register file, timer/irq and read-data register; set beats W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_timer <= '0;
      r_cmp   <= 32'hFFFF_FFFF;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
      r_led   <= '0;
    end else begin
      r_timer <= w_timer_nxt;
      if (w_wr_cmp) r_cmp <= bus.data_sram_wdata;
      if (w_wr_led) r_led <= bus.data_sram_wdata[LED_W-1:0];
      if (w_irq_set)
        r_irq <= 1'b1;
      else if (w_wr_status && bus.data_sram_wdata[STATUS_IRQ_BIT])
        r_irq <= 1'b0;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_wr_status && bus.data_sram_wdata[STATUS_OVF_BIT])
        r_ovf <= 1'b0;
      if (w_rd) r_rdata <= (w_region == REGION_MMIO) ? w_mmio_rd : r_ram[w_idx];
    end
  end

  assign bus.data_sram_rdata = r_rdata;
  assign timer_irq_o         = r_irq;
  assign led_o               = r_led;
  assign tx_valid_o          = ~w_tx_empty;
  assign w_unused            = ^w_tx_count;
endmodule
